// File: rtl/smg_scan_decoder.sv
// smg_scan_decoder
//
// Receive-side decoder for a multiplexed 3-digit 7-segment bus. The bus is
// sampled and each digit is accepted only after it has held the same pattern
// for STABLE_CYCLES consecutive samples. Accepted digits are decoded to BCD
// and staged. A complete frame is one digit in each of the three positions,
// accepted in any order. When a frame completes it is published on Number_Sig.
//
// Ports
//   CLK           in   1   system clock, rising edge
//   RSTn          in   1   synchronous reset, active-low
//   SMG_Data      in   8   segment lines, active-low; [7]=DP, [6:0]=G..A
//   Scan_Sig      in   3   digit selects, active-low one-hot
//                          110=ones, 101=tens, 011=hundreds, 111=blank
//   Number_Sig    out  12  last complete frame {hundreds, tens, ones} BCD
//   Number_Valid  out  1   one-cycle pulse when Number_Sig is updated
//   Code_Err      out  1   one-cycle pulse on an accepted illegal pattern
//
// Frame FSM
//   state    | meaning
//   COLLECT  | gathering digits; mask marks positions captured so far
//   PUBLISH  | one cycle: copy staging to Number_Sig, pulse Number_Valid

module smg_scan_decoder #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [7:0]  SMG_Data,
  input  logic [2:0]  Scan_Sig,
  output logic [11:0] Number_Sig,
  output logic        Number_Valid,
  output logic        Code_Err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE_CYCLES - 2);

  localparam logic [2:0] SCAN_ONES  = 3'b110;
  localparam logic [2:0] SCAN_TENS  = 3'b101;
  localparam logic [2:0] SCAN_HUND  = 3'b011;
  localparam logic [2:0] SCAN_BLANK = 3'b111;

  // Sample layout: {SMG_Data[7:0], Scan_Sig[2:0]}
  localparam logic [10:0] SAMPLE_IDLE = {8'hFF, 3'b111};

  typedef enum logic {
    COLLECT = 1'b0,
    PUBLISH = 1'b1
  } state_t;

  // ------------------------------------------------------------------
  // Input sample / previous sample
  // ------------------------------------------------------------------
  logic [10:0] s_q, s_d;
  logic [10:0] p_q, p_d;

  assign s_d = {SMG_Data, Scan_Sig};
  assign p_d = s_q;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      s_q <= SAMPLE_IDLE;
      p_q <= SAMPLE_IDLE;
    end else begin
      s_q <= s_d;
      p_q <= p_d;
    end
  end

  // ------------------------------------------------------------------
  // Stability counter and acceptance event
  // ------------------------------------------------------------------
  logic [CW-1:0] cnt_q, cnt_d;
  logic          same;
  logic          acc_q, acc_d;
  logic [9:0]    acc_pat_q, acc_pat_d;   // {SMG_Data[6:0], Scan_Sig}; DP dropped

  assign same = (s_q == p_q);

  always_comb begin
    cnt_d = cnt_q;
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // The event fires only on the S-2 -> S-1 step, so a held pattern is
  // accepted once even though the counter keeps running up to saturation.
  // The pattern is latched with the event because the pins (and s_q) may
  // already carry the next digit by the time it is processed.
  assign acc_d     = same && (cnt_q == CNT_FIRE);
  assign acc_pat_d = s_q[9:0];

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      acc_pat_q <= SAMPLE_IDLE[9:0];
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      acc_pat_q <= acc_pat_d;
    end
  end

  // ------------------------------------------------------------------
  // Segment decode (active-low, G..A)
  // ------------------------------------------------------------------
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    // returns {legal, bcd[3:0]}
    logic [4:0] r;
    case (seg)
      7'h40:   r = {1'b1, 4'd0};
      7'h79:   r = {1'b1, 4'd1};
      7'h24:   r = {1'b1, 4'd2};
      7'h30:   r = {1'b1, 4'd3};
      7'h19:   r = {1'b1, 4'd4};
      7'h12:   r = {1'b1, 4'd5};
      7'h02:   r = {1'b1, 4'd6};
      7'h78:   r = {1'b1, 4'd7};
      7'h00:   r = {1'b1, 4'd8};
      7'h10:   r = {1'b1, 4'd9};
      default: r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  logic [2:0] acc_scan;
  logic [4:0] dec;
  logic       dec_ok;
  logic [3:0] dec_bcd;

  assign acc_scan = acc_pat_q[2:0];
  assign dec      = seg_decode(acc_pat_q[9:3]);
  assign dec_ok   = dec[4];
  assign dec_bcd  = dec[3:0];

  // ------------------------------------------------------------------
  // Frame FSM
  // ------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [2:0]  mask_q, mask_d;
  logic [11:0] stage_q, stage_d;
  logic [11:0] number_q, number_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    stage_d  = stage_q;
    number_d = number_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      COLLECT: begin
        if (acc_q) begin
          if (acc_scan == SCAN_BLANK) begin
            // blank period between digits: nothing to do
          end else if (!dec_ok ||
                       !(acc_scan == SCAN_ONES ||
                         acc_scan == SCAN_TENS ||
                         acc_scan == SCAN_HUND)) begin
            // illegal code or select: drop the partial frame, keep staging
            err_d  = 1'b1;
            mask_d = 3'b000;
          end else begin
            case (acc_scan)
              SCAN_ONES: begin
                stage_d[3:0] = dec_bcd;
                mask_d[0]    = 1'b1;
              end
              SCAN_TENS: begin
                stage_d[7:4] = dec_bcd;
                mask_d[1]    = 1'b1;
              end
              default: begin
                stage_d[11:8] = dec_bcd;
                mask_d[2]     = 1'b1;
              end
            endcase
            if (mask_d == 3'b111) begin
              state_d = PUBLISH;
            end
          end
        end
      end

      PUBLISH: begin
        number_d = stage_q;
        valid_d  = 1'b1;
        mask_d   = 3'b000;
        state_d  = COLLECT;
      end

      default: begin
        state_d = COLLECT;
        mask_d  = 3'b000;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q  <= COLLECT;
      mask_q   <= 3'b000;
      stage_q  <= 12'h000;
      number_q <= 12'h000;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      stage_q  <= stage_d;
      number_q <= number_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign Number_Sig   = number_q;
  assign Number_Valid = valid_q;
  assign Code_Err     = err_q;

endmodule
